// File: rtl/fft_twiddle_mult.sv
// Twiddle-multiply stage of the FFT datapath: steps the twiddle ROM address per
// accepted sample, then multiplies, rounds and saturates with 2-cycle latency.
module fft_twiddle_mult #(
  parameter int data_width    = 16,
  parameter int twiddle_width = 16,
  parameter int address_width = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               stage,
  input  logic                     in_valid,
  input  logic [data_width-1:0]    in_real,
  input  logic [data_width-1:0]    in_imag,
  output logic [address_width-1:0] rom_address,
  input  logic [twiddle_width-1:0] rom_datar,
  input  logic [twiddle_width-1:0] rom_datai,
  output logic                     out_valid,
  output logic [data_width-1:0]    out_real,
  output logic [data_width-1:0]    out_imag,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int IW = address_width - 2;
  localparam int PW = data_width + twiddle_width + 1;
  localparam int SW = PW + 2 - twiddle_width;
  localparam logic [PW:0] RND = {{(PW - twiddle_width + 2){1'b0}}, 1'b1, {(twiddle_width - 2){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                 r_state, w_next_state;
  logic                   w_busy_next;
  logic [1:0]             r_stage;
  logic [IW-1:0]          r_idx;
  logic                   w_accept, w_last_accept;
  logic                   r_a_valid, r_a_last, r_p_valid, r_p_last;
  logic [data_width-1:0]  r_a_re, r_a_im;
  logic signed [PW-1:0]   w_ar_x, w_ai_x, w_wr_x, w_wi_x, w_pr, w_pi;
  logic signed [PW-1:0]   r_p_re, r_p_im;
  logic [PW:0]            w_sum_re, w_sum_im;
  logic                   r_out_valid, r_frame_done, r_busy;
  logic [data_width-1:0]  r_out_re, r_out_im;

  function automatic logic [data_width-1:0] f_sat(input logic [SW-1:0] v);
    logic [data_width-1:0] res;
    if (!v[SW-1] && (|v[SW-2:data_width-1])) res = {1'b0, {(data_width-1){1'b1}}};
    else if (v[SW-1] && !(&v[SW-2:data_width-1])) res = {1'b1, {(data_width-1){1'b0}}};
    else res = v[data_width-1:0];
    return res;
  endfunction

  // start always takes priority, so a sample presented with it is dropped
  assign w_accept      = (r_state == S_RUN) && in_valid && !start;
  assign w_last_accept = w_accept && (r_idx == {IW{1'b1}});
  assign rom_address   = {r_stage, r_idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN; else w_next_state = S_IDLE;
      S_RUN:   if (start) w_next_state = S_RUN; else if (w_last_accept) w_next_state = S_DRAIN; else w_next_state = S_RUN;
      S_DRAIN: if (start) w_next_state = S_RUN; else if (r_p_valid && r_p_last) w_next_state = S_IDLE; else w_next_state = S_DRAIN;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_next = 1'b0;
    if (w_next_state != S_IDLE) w_busy_next = 1'b1;
    else w_busy_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= 2'd0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      if (start) begin
        r_stage <= stage;
        r_idx   <= '0;
      end else if (w_accept) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  // A restart strips the end-of-frame tag from anything still in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
      r_a_re    <= '0;
      r_a_im    <= '0;
      r_p_valid <= 1'b0;
      r_p_last  <= 1'b0;
      r_p_re    <= '0;
      r_p_im    <= '0;
    end else begin
      r_a_valid <= w_accept;
      r_a_last  <= w_last_accept;
      if (w_accept) begin
        r_a_re <= in_real;
        r_a_im <= in_imag;
      end
      r_p_valid <= r_a_valid;
      r_p_last  <= r_a_last && !start;
      if (r_a_valid) begin
        r_p_re <= w_pr;
        r_p_im <= w_pi;
      end
    end
  end

  assign w_ar_x = {{(PW-data_width){r_a_re[data_width-1]}}, r_a_re};
  assign w_ai_x = {{(PW-data_width){r_a_im[data_width-1]}}, r_a_im};
  assign w_wr_x = {{(PW-twiddle_width){rom_datar[twiddle_width-1]}}, rom_datar};
  assign w_wi_x = {{(PW-twiddle_width){rom_datai[twiddle_width-1]}}, rom_datai};
  assign w_pr   = w_ar_x * w_wr_x - w_ai_x * w_wi_x;
  assign w_pi   = w_ar_x * w_wi_x + w_ai_x * w_wr_x;

  assign w_sum_re = {r_p_re[PW-1], r_p_re} + RND;
  assign w_sum_im = {r_p_im[PW-1], r_p_im} + RND;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_re     <= '0;
      r_out_im     <= '0;
    end else begin
      r_out_valid  <= r_p_valid;
      r_frame_done <= r_p_valid && r_p_last && !start;
      if (r_p_valid) begin
        r_out_re <= f_sat(w_sum_re[PW:twiddle_width-1]);
        r_out_im <= f_sat(w_sum_im[PW:twiddle_width-1]);
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_real   = r_out_re;
  assign out_imag   = r_out_im;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Directed bench for fft_twiddle_mult: ROM model, hand vectors plus a reference
// product model feeding a scoreboard that also checks latency and frame_done.
module tb_fft_twiddle_mult;

  logic        clk, rst, start, in_valid, out_valid, busy, frame_done;
  logic [1:0]  stage;
  logic [15:0] in_real, in_imag, rom_datar, rom_datai, out_real, out_imag;
  logic [5:0]  rom_address;

  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] rom_r [64];
  logic [15:0] rom_i [64];
  int          cyc = 0;
  int          fd_count = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  fft_twiddle_mult dut (
    .clk(clk), .rst(rst), .start(start), .stage(stage), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag), .rom_address(rom_address),
    .rom_datar(rom_datar), .rom_datai(rom_datai), .out_valid(out_valid),
    .out_real(out_real), .out_imag(out_imag), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rom_datar <= rom_r[rom_address];
    rom_datai <= rom_i[rom_address];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [15:0] ar, ai, wr, wi, input bit imag);
    longint p, q, d;
    if (imag) p = longint'($signed(ar)) * longint'($signed(wi)) + longint'($signed(ai)) * longint'($signed(wr));
    else      p = longint'($signed(ar)) * longint'($signed(wr)) - longint'($signed(ai)) * longint'($signed(wi));
    q = p + 64'sd16384;
    if (q >= 0) d = q / 64'sd32768;
    else        d = -((-q + 64'sd32767) / 64'sd32768);
    if (d > 64'sd32767)  d = 64'sd32767;
    if (d < -64'sd32768) d = -64'sd32768;
    return d[15:0];
  endfunction

  // scoreboard: every out_valid must match the oldest expectation, on its cycle
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("out_real", {16'd0, out_real}, {16'd0, mon_e.r});
        check_eq("out_imag", {16'd0, out_imag}, {16'd0, mon_e.i});
        check_eq("frame_done", {31'd0, frame_done}, {31'd0, mon_e.last});
        check_eq("latency", cyc, mon_e.cyc);
        if (mon_e.last) check_eq("busy_at_done", {31'd0, busy}, 32'd0);
        if (frame_done) fd_count++;
      end
    end else if (!rst && frame_done) begin
      check_eq("frame_done_without_valid", 32'd1, 32'd0);
    end
  end

  task automatic send_exp(input logic [15:0] re, im, input logic [5:0] addr, input bit last,
                          input logic [15:0] er, ei);
    exp_t e;
    check_eq("rom_address", {26'd0, rom_address}, {26'd0, addr});
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    e.r = er; e.i = ei; e.last = last; e.cyc = cyc + 3;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] re, im, input logic [5:0] addr, input bit last);
    send_exp(re, im, addr, last, ref_prod(re, im, rom_r[addr], rom_i[addr], 1'b0),
             ref_prod(re, im, rom_r[addr], rom_i[addr], 1'b1));
  endtask

  task automatic do_start(input logic [1:0] s, input logic iv);
    start    = 1'b1;
    stage    = s;
    in_valid = iv;
    in_real  = 16'h7777;
    in_imag  = 16'h1111;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check_eq("drain_empty", exp_q.size(), 32'd0);
  endtask

  function automatic logic [15:0] samp_re(input int j);
    if (j == 7) return 16'h7FFF;
    return 16'(j * 2111 - 15000);
  endfunction

  function automatic logic [15:0] samp_im(input int j);
    if (j == 7) return 16'h8000;
    return 16'(17000 - j * 1900);
  endfunction

  initial begin
    for (int k = 0; k < 64; k++) begin
      rom_r[k] = 16'(32767 - k * 500);
      rom_i[k] = 16'(k * 613 - 19000);
    end
    rom_r[0] = 16'h7FFF; rom_i[0] = 16'h0000;
    rom_r[1] = 16'h7D89; rom_i[1] = 16'hE707;
    rom_r[4] = 16'h5A82; rom_i[4] = 16'hA57E;
    for (int k = 48; k < 64; k++) begin
      rom_r[k] = 16'h7FFF; rom_i[k] = 16'h0000;
    end
    rst = 1'b1; start = 1'b0; stage = 2'd0; in_valid = 1'b0;
    in_real = 16'd0; in_imag = 16'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_real", {16'd0, out_real}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rom_address", {26'd0, rom_address}, 32'd0);
    check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    // in_valid while idle does nothing
    in_valid = 1'b1; in_real = 16'h1234; in_imag = 16'h4321;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_eq("idle_rom_address", {26'd0, rom_address}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    // stage 0 frame with hand-computed leading vectors
    do_start(2'd0, 1'b0);
    check_eq("run_busy", {31'd0, busy}, 32'd1);
    send_exp(16'h4000, 16'h0000, 6'h00, 1'b0, 16'h4000, 16'h0000);
    send_exp(16'h4000, 16'h0000, 6'h01, 1'b0, 16'h3EC5, 16'hF384);
    send(samp_re(2), samp_im(2), 6'h02, 1'b0);
    send(samp_re(3), samp_im(3), 6'h03, 1'b0);
    send_exp(16'h8000, 16'h8000, 6'h04, 1'b0, 16'h8000, 16'h0000);
    for (int j = 5; j < 16; j++) send(samp_re(j), samp_im(j), 6'(j), j == 15);
    wait_drain();
    check_eq("fd_count_f0", fd_count, 32'd1);

    // stage 2 back-to-back, then in_valid during drain is ignored
    do_start(2'd2, 1'b0);
    for (int j = 0; j < 16; j++) send(samp_re(j + 3), samp_im(j + 3), 6'(32 + j), j == 15);
    in_valid = 1'b1; in_real = 16'h2222; in_imag = 16'h3333;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_drain();
    check_eq("drain_rom_address", {26'd0, rom_address}, 32'h20);
    check_eq("fd_count_f2", fd_count, 32'd2);
    check_eq("idle_busy_after_f2", {31'd0, busy}, 32'd0);

    // restart after 5 samples with start+in_valid together, then gapped frame
    do_start(2'd1, 1'b0);
    for (int j = 0; j < 5; j++) send(samp_re(j), samp_im(j), 6'(16 + j), 1'b0);
    do_start(2'd3, 1'b1);
    send_exp(16'h7FFF, 16'h0000, 6'h30, 1'b0, 16'h7FFE, 16'h0000);
    for (int j = 1; j < 16; j++) begin
      if (j % 4 != 0) repeat ((j % 3) + 1) @(negedge clk);
      send(samp_re(j), samp_im(j), 6'(48 + j), j == 15);
    end
    wait_drain();
    check_eq("fd_count_f3", fd_count, 32'd3);

    // reset with two samples in flight
    do_start(2'd0, 1'b0);
    send(samp_re(9), samp_im(9), 6'h00, 1'b0);
    send(samp_re(10), samp_im(10), 6'h01, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_out_real", {16'd0, out_real}, 32'd0);
    check_eq("mid_rst_out_imag", {16'd0, out_imag}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_rom_address", {26'd0, rom_address}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("fd_count_end", fd_count, 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_mult.md
Name: fft_twiddle_mult

Overview:
- Twiddle-multiply stage of the 1024-point WISHBONE FFT datapath.
- Sits directly downstream of the 64-entry twiddle ROM (6-bit address = {stage[1:0], index[3:0]}, registered output, 1-cycle latency, Q1.15 values, 0x7FFF = +1).
- Accepts a 16-sample butterfly-leg frame and drives the ROM address for each sample.
- Aligns each sample with the returned twiddle, computes the complex product, rounds and saturates, and emits one product per input sample.

Parameters:
- data_width, 16, signed width of sample real/imag in and out
- twiddle_width, 16, signed width of ROM datar/datai (Q1.15)
- address_width, 6, ROM address width; upper 2 bits are stage, lower 4 bits are index

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; latches stage, clears index, begins a frame
- stage  in  2  twiddle group select; sampled only when start=1
- in_valid  in  1  sample-accept strobe
- in_real  in  data_width  sample real part, signed
- in_imag  in  data_width  sample imaginary part, signed
- rom_address  out  address_width  {stage_q, idx}; to ROM address
- rom_datar  in  twiddle_width  ROM real twiddle, valid 1 cycle after address
- rom_datai  in  twiddle_width  ROM imaginary twiddle
- out_valid  out  1  product valid
- out_real  out  data_width  product real part
- out_imag  out  data_width  product imaginary part
- busy  out  1  frame in progress
- frame_done  out  1  pulse coincident with out_valid of the 16th sample

Behaviour:
- Reset (async, rst=1):
  - stage_q=0, idx=0, all pipeline valids=0, busy=0.
  - out_valid=0, out_real=0, out_imag=0, frame_done=0, rom_address=0.
  - Reset mid-frame discards all in-flight samples; no outputs follow after release.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start: stage_q<=stage, idx<=0, busy<=1.
  - RUN: each in_valid=1 accepts a sample and idx<=idx+1.
    - Acceptance at idx=15 wraps idx to 0 and moves to DRAIN.
  - DRAIN -> IDLE, busy<=0, at the edge that outputs the 16th product.
- rom_address = {stage_q, idx}, driven combinationally from registers; stable during the accept cycle.
- in_valid in IDLE or DRAIN is ignored: no idx change, no output.
- start in RUN or DRAIN:
  - reloads stage_q, clears idx, enters RUN.
  - In-flight products still emerge.
  - frame_done is asserted only for the new frame's 16th sample.
- start and in_valid in the same cycle: start wins; the sample is ignored.
- Pipeline, for a sample accepted at edge n:
  - Edge n: sample registered as a_r, a_i; ROM registers w_r, w_i.
  - Edge n+1:
    - p_r = a_r*w_r - a_i*w_i, 33-bit signed.
    - p_i = a_r*w_i + a_i*w_r, 33-bit signed.
  - Edge n+2: out = sat(floor((p + 2^14) / 2^15)), arithmetic shift; out_valid=1 for one cycle.
  - Latency is 2 cycles after the accept edge.
  - Throughput is 1 sample/cycle; back-to-back in_valid is supported.
- Saturation: results above 2^(data_width-1)-1 clamp to 0x7FFF; results below -2^(data_width-1) clamp to 0x8000.
- out_real and out_imag hold their last value while out_valid=0.
- Stage 3 (unity twiddles) is not bit-exact pass-through: 0x7FFF*0x7FFF gives 0x7FFE.

Test Plan:
- Reset check: assert rst mid-frame with 2 samples in flight -> out_valid=0, outputs 0x0000, busy=0 immediately; no out_valid after release.
- Stage 0, idx 0: start with stage=0, then sample (0x4000, 0x0000); twiddle (0x7FFF, 0x0000) -> rom_address=0x00; out (0x4000, 0x0000) two edges after accept.
- Stage 0, idx 1: second sample (0x4000, 0x0000), rom_address=0x01, twiddle (0x7D89, 0xE707) -> out (0x3EC5, 0xF384).
- Saturation: stage 0, idx 4, sample (0x8000, 0x8000), twiddle (0x5A82, 0xA57E) -> out_real=0x8000 (saturated from -46340), out_imag=0x0000.
- Full frame: 16 back-to-back samples with stage=2 -> rom_address steps 0x20..0x2F; 16 consecutive out_valid pulses; frame_done only on the last; busy drops on the same edge.
- Restart and gaps: start asserted mid-frame after 5 samples, and in_valid gaps of 1-3 cycles -> idx restarts at 0 with the new stage; the 5 earlier products still emerge; gaps produce matching out_valid gaps; in_valid while IDLE produces nothing.
